// File: rtl/barrel_shifter_pkg.sv
// Shared types and helpers for the rotate-type barrel shifter.
// Direction encoding and per-stage rotate amounts are defined once here.
package barrel_shifter_pkg;

  localparam int DEFAULT_DW = 4;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Stage s of the mux chain rotates by 2^s positions.
  function automatic int stage_amt(input int s);
    return 1 << s;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One mux stage: rotates the word by a fixed AMT positions when en=1,
// in the direction selected by left; otherwise passes the word through.
module barrel_stage
  import barrel_shifter_pkg::*;
#(
  parameter int DW  = DEFAULT_DW,
  parameter int AMT = 1
) (
  input  logic          en,
  input  logic          left,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_d
);

  logic [DW-1:0] rot_left;
  logic [DW-1:0] rot_right;

  // Both rotations are pure rewiring; the index math is resolved at elaboration.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_bit
      assign rot_left[(gi + AMT) % DW] = i_d[gi];
      assign rot_right[gi]             = i_d[(gi + AMT) % DW];
    end
  endgenerate

  always_comb begin
    o_d = i_d;
    if (en) begin
      if (dir_e'(left) == DIR_LEFT) begin
        o_d = rot_left;
      end else begin
        o_d = rot_right;
      end
    end
  end

endmodule

// File: rtl/barrel_shifter.sv
// Rotate-type barrel shifter: log2(DW) conditional rotate stages feeding a
// single output register. One result per cycle, latency of one cycle.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int SW = $clog2(DW)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          left,
  input  logic [SW-1:0] shift,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data
);

  // stage_data[s] is the word after the first s stages have been applied.
  logic [DW-1:0] stage_data [0:SW];
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  assign stage_data[0] = i_data;

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_stage
      barrel_stage #(
        .DW  (DW),
        .AMT (stage_amt(gi))
      ) u_stage (
        .en   (shift[gi]),
        .left (left),
        .i_d  (stage_data[gi]),
        .o_d  (stage_data[gi+1])
      );
    end
  endgenerate

  always_comb begin
    data_d = stage_data[SW];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: stimulus pushes expected results,
// an independent monitor pops and compares one cycle after each edge.
module tb_barrel_shifter;

  localparam int DW = 4;
  localparam int SW = $clog2(DW);

  logic          i_clk;
  logic          i_rst;
  logic          left;
  logic [SW-1:0] shift;
  logic [DW-1:0] i_data;
  logic [DW-1:0] o_data;

  logic [DW-1:0] exp_q [$];
  string         name_q [$];

  int n_pass;
  int n_total;

  barrel_shifter #(.DW(DW)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .left   (left),
    .shift  (shift),
    .i_data (i_data),
    .o_data (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference rotate: duplicate the word and slice the shifted window out.
  function automatic logic [DW-1:0] rot_model(input logic [DW-1:0] d,
                                               input int n,
                                               input logic l);
    logic [2*DW-1:0] dd;
    dd = {d, d};
    if (l) begin
      dd = dd << n;
      return dd[2*DW-1:DW];
    end else begin
      dd = dd >> n;
      return dd[DW-1:0];
    end
  endfunction

  // Apply one input vector for the coming edge and record what it must produce.
  task automatic drive(input logic r, input logic l, input int s,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp,
                       input string nm);
    @(negedge i_clk);
    i_rst  = r;
    left   = l;
    shift  = SW'(s);
    i_data = d;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor: the output is valid every cycle, so pop one entry per edge.
  initial begin
    logic [DW-1:0] exp;
    string nm;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        n_total++;
        if (o_data === exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: o_data=%b expected %b", nm, o_data, exp);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic l;
    int s;
    n_pass  = 0;
    n_total = 0;
    i_rst   = 1'b1;
    left    = 1'b0;
    shift   = '0;
    i_data  = '0;

    drive(1'b1, 1'b1, 2, 4'b1011, 4'b0000, "reset_0");
    drive(1'b1, 1'b1, 2, 4'b1011, 4'b0000, "reset_1");
    drive(1'b0, 1'b1, 2, 4'b1011, 4'b1110, "post_reset");

    drive(1'b0, 1'b1, 1, 4'b1001, 4'b0011, "left_1");
    drive(1'b0, 1'b1, 3, 4'b1001, 4'b1100, "left_3");
    drive(1'b0, 1'b0, 1, 4'b1001, 4'b1100, "right_1");
    drive(1'b0, 1'b0, 2, 4'b1001, 4'b0110, "right_2");
    drive(1'b0, 1'b0, 0, 4'b0110, 4'b0110, "pass_right");
    drive(1'b0, 1'b1, 0, 4'b0110, 4'b0110, "pass_left");
    drive(1'b0, 1'b1, 1, 4'b0001, 4'b0010, "equiv_left1");
    drive(1'b0, 1'b0, 3, 4'b0001, 4'b0010, "equiv_right3");
    drive(1'b0, 1'b1, 3, 4'b0000, 4'b0000, "zeros");
    drive(1'b0, 1'b0, 2, 4'b1111, 4'b1111, "ones");
    drive(1'b0, 1'b1, 2, 4'b1000, 4'b0010, "left_2_msb");

    for (int i = 0; i < 100; i++) begin
      d = DW'($urandom);
      l = 1'($urandom);
      s = int'($urandom_range(DW - 1, 0));
      if (i == 50) begin
        drive(1'b1, l, s, d, '0, "rand_reset");
      end else begin
        drive(1'b0, l, s, d, rot_model(d, s, l), $sformatf("rand_%0d", i));
      end
    end

    repeat (3) @(negedge i_clk);
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
